// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding, parity-type constants and parity helper
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam PARITY_NONE = "none";
  localparam PARITY_EVEN = "even";
  localparam PARITY_ODD  = "odd";
  // odd=0: mismatch when data^parity is 1; odd=1: mismatch when it is 0
  function automatic logic parity_mismatch(input logic [7:0] data, input logic pbit, input logic odd);
    return ^data ^ pbit ^ odd;
  endfunction
endpackage

// File: rtl/uart_clk_div.sv
// uart_clk_div: bit-period divider with a mid-period sample strobe
// CLK/RST: clock, async active-high reset
// CLEAR: hold counter at zero; ENABLE: count; DIV_MARK: strobe at DIV_MARK_POS
module uart_clk_div #(
  parameter int DIV_MAX_VAL  = 16,
  parameter int DIV_MARK_POS = 8
) (
  input  logic CLK,
  input  logic RST,
  input  logic CLEAR,
  input  logic ENABLE,
  output logic DIV_MARK
);
  localparam int W = DIV_MAX_VAL > 1 ? $clog2(DIV_MAX_VAL) : 1;
  logic [W-1:0] cnt;
  always_ff @(posedge CLK or posedge RST)
    if (RST) cnt <= '0;
    else if (CLEAR) cnt <= '0;
    else if (ENABLE) cnt <= cnt == W'(DIV_MAX_VAL - 1) ? '0 : cnt + W'(1);
  assign DIV_MARK = ENABLE && cnt == W'(DIV_MARK_POS);
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8-bit UART receiver with optional parity and frame-error detection
// CLK/RST: clock, async active-high reset; UART_RXD: serial line, idle high
// DOUT: last good byte; DOUT_VLD/FRAME_ERROR/PARITY_ERROR: one-cycle pulses
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ    = 50000000,
  parameter int BAUD_RATE   = 115200,
  parameter     PARITY_TYPE = "none"
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       UART_RXD,
  output logic [7:0] DOUT,
  output logic       DOUT_VLD,
  output logic       FRAME_ERROR,
  output logic       PARITY_ERROR
);
  localparam int DIV_MAX_VAL = CLK_FREQ / BAUD_RATE;
  localparam bit HAS_PAR = PARITY_TYPE != PARITY_NONE;
  localparam bit IS_ODD  = PARITY_TYPE == PARITY_ODD;
  state_t state, next;
  logic [1:0] sync;
  logic rxd, rxd_d, fall, mark, clear, enable, shift_en, par_en, stop_en, par_err;
  logic [2:0] bit_cnt;
  logic [7:0] shift;
  uart_clk_div #(.DIV_MAX_VAL(DIV_MAX_VAL), .DIV_MARK_POS(DIV_MAX_VAL / 2)) div (
    .CLK(CLK), .RST(RST), .CLEAR(clear), .ENABLE(enable), .DIV_MARK(mark)
  );
  assign rxd  = sync[1];
  // a start edge needs a real high-to-low step, so a held break never retriggers
  assign fall = rxd_d & ~rxd;
  always_ff @(posedge CLK or posedge RST)
    if (RST) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = fall ? START : IDLE;
      START:   next = mark ? (rxd ? IDLE : DATA) : START;
      DATA:    next = mark && bit_cnt == 3'd7 ? (HAS_PAR ? PARITY : STOP) : DATA;
      PARITY:  next = mark ? STOP : PARITY;
      STOP:    next = mark ? IDLE : STOP;
      default: next = IDLE;
    endcase
  end
  always_comb begin
    clear    = state == IDLE;
    enable   = state != IDLE;
    shift_en = state == DATA && mark;
    par_en   = state == PARITY && mark;
    stop_en  = state == STOP && mark;
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      sync         <= 2'b11;
      rxd_d        <= 1'b1;
      bit_cnt      <= '0;
      shift        <= '0;
      par_err      <= 1'b0;
      DOUT         <= '0;
      DOUT_VLD     <= 1'b0;
      FRAME_ERROR  <= 1'b0;
      PARITY_ERROR <= 1'b0;
    end else begin
      sync         <= {sync[0], UART_RXD};
      rxd_d        <= rxd;
      DOUT_VLD     <= stop_en & rxd;
      FRAME_ERROR  <= stop_en & ~rxd;
      PARITY_ERROR <= stop_en & rxd & HAS_PAR & par_err;
      if (stop_en && rxd) DOUT <= shift;
      if (shift_en) begin
        shift   <= {rxd, shift[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (par_en) par_err <= parity_mismatch(shift, rxd, IS_ODD);
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx at 16 clk/bit, no-parity and even-parity instances
module tb_uart_rx;
  import uart_pkg::*;
  typedef struct packed {logic [7:0] data; logic perr;} exp_t;
  logic clk = 0, rst = 1, rxd = 1, rxd_p = 1;
  logic [7:0] dout, dout_p;
  logic vld, fe, pe, vld_p, fe_p, pe_p;
  logic vld_q = 0, fe_q = 0;
  exp_t q[$], qp[$];
  exp_t e, ep;
  int tests = 0, fails = 0, cyc = 0, t_edge = 0, t_vld = 0;
  int vld_cnt = 0, fe_cnt = 0, vld_cnt_p = 0, pe_cnt_p = 0;
  int v0, f0;
  uart_rx #(.CLK_FREQ(1600000), .BAUD_RATE(100000), .PARITY_TYPE("none")) dut (
    .CLK(clk), .RST(rst), .UART_RXD(rxd), .DOUT(dout), .DOUT_VLD(vld),
    .FRAME_ERROR(fe), .PARITY_ERROR(pe)
  );
  uart_rx #(.CLK_FREQ(1600000), .BAUD_RATE(100000), .PARITY_TYPE("even")) dut_p (
    .CLK(clk), .RST(rst), .UART_RXD(rxd_p), .DOUT(dout_p), .DOUT_VLD(vld_p),
    .FRAME_ERROR(fe_p), .PARITY_ERROR(pe_p)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) if (!rst) begin
    if (vld) begin
      vld_cnt++;
      t_vld = cyc;
      check("vld_fe_excl", fe, 0);
      check("vld_width", vld_q, 0);
      check("q_nonempty", q.size() != 0, 1);
      if (q.size() != 0) begin
        e = q.pop_front();
        check("dout", dout, e.data);
        check("perr", pe, e.perr);
      end
    end
    if (fe) begin
      fe_cnt++;
      check("fe_width", fe_q, 0);
    end
    vld_q = vld;
    fe_q = fe;
  end
  always @(negedge clk) if (!rst) begin
    if (vld_p) begin
      vld_cnt_p++;
      check("qp_nonempty", qp.size() != 0, 1);
      if (qp.size() != 0) begin
        ep = qp.pop_front();
        check("dout_p", dout_p, ep.data);
        check("perr_p", pe_p, ep.perr);
      end
    end
    if (pe_p) begin
      pe_cnt_p++;
      check("pe_with_vld", vld_p, 1);
    end
  end
  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic drive(input bit par, input logic b);
    if (par) rxd_p = b;
    else rxd = b;
    wait_clk(16);
  endtask
  task automatic send(input logic [7:0] d, input logic stop, input bit par, input logic pbit);
    if (stop) begin
      if (par) qp.push_back('{d, ^d ^ pbit});
      else q.push_back('{d, 1'b0});
    end
    drive(par, 1'b0);
    for (int i = 0; i < 8; i++) drive(par, d[i]);
    if (par) drive(par, pbit);
    drive(par, stop);
  endtask
  initial begin
    wait_clk(3);
    check("rst_dout", dout, 0);
    check("rst_vld", vld, 0);
    check("rst_fe", fe, 0);
    check("rst_pe", pe, 0);
    check("rst_state", dut.state, IDLE);
    rst = 0;
    wait_clk(5);
    t_edge = cyc;
    send(8'hA5, 1, 0, 0);
    wait_clk(20);
    check("a5_count", vld_cnt, 1);
    check("a5_latency", (t_vld - t_edge) inside {[148:160]}, 1);
    send(8'h00, 1, 0, 0);
    send(8'hFF, 1, 0, 0);
    send(8'h3C, 1, 0, 0);
    wait_clk(20);
    check("b2b_count", vld_cnt, 4);
    v0 = vld_cnt;
    f0 = fe_cnt;
    send(8'h55, 0, 0, 0);
    wait_clk(640);
    check("fe_once", fe_cnt, f0 + 1);
    check("fe_no_vld", vld_cnt, v0);
    check("dout_hold", dout, 8'h3C);
    rxd = 1;
    wait_clk(64);
    check("break_quiet", fe_cnt, f0 + 1);
    send(8'h12, 1, 0, 0);
    wait_clk(20);
    check("after_break", vld_cnt, v0 + 1);
    v0 = vld_cnt;
    f0 = fe_cnt;
    rxd = 0;
    wait_clk(4);
    rxd = 1;
    wait_clk(40);
    check("glitch_vld", vld_cnt, v0);
    check("glitch_fe", fe_cnt, f0);
    check("glitch_idle", dut.state, IDLE);
    send(8'h07, 1, 1, 1'b0);
    send(8'h07, 1, 1, 1'b1);
    wait_clk(20);
    check("par_count", vld_cnt_p, 2);
    check("par_err_count", pe_cnt_p, 1);
    drive(0, 1'b0);
    for (int i = 0; i < 4; i++) drive(0, 1'b1);
    rxd = 1'b1;
    wait_clk(8);
    rst = 1;
    wait_clk(3);
    check("midrst_dout", dout, 0);
    check("midrst_state", dut.state, IDLE);
    rst = 0;
    wait_clk(200);
    check("midrst_no_vld", vld_cnt, v0);
    check("midrst_no_fe", fe_cnt, f0);
    send(8'h81, 1, 0, 0);
    wait_clk(20);
    check("post_rst_rx", vld_cnt, v0 + 1);
    check("q_drained", q.size(), 0);
    check("qp_drained", qp.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLK_FREQ, default 50000000, system clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 115200, serial bit rate in baud.
REQ-003 Parameter PARITY_TYPE, default "none", one of "none"/"even"/"odd".
REQ-004 Port CLK  input  1  system clock; all logic on rising edge.
REQ-005 Port RST  input  1  asynchronous, active-high reset.
REQ-006 Port UART_RXD  input  1  asynchronous serial line, idle high.
REQ-007 Port DOUT  output  8  last received data byte.
REQ-008 Port DOUT_VLD  output  1  one-cycle pulse: DOUT holds a new byte.
REQ-009 Port FRAME_ERROR  output  1  one-cycle pulse: stop bit sampled low.
REQ-010 Port PARITY_ERROR  output  1  one-cycle pulse, coincident with DOUT_VLD: parity mismatch.

Function
REQ-011 UART_RXD SHALL pass through a 2-flop synchronizer before any use; both flops reset to 1.
REQ-012 Bit period DIV_MAX_VAL = CLK_FREQ/BAUD_RATE (integer division); mid-bit mark position = DIV_MAX_VAL/2.
REQ-013 Frame: 1 start bit (0), 8 data bits LSB first, optional parity bit, 1 stop bit (1).
REQ-014 FSM states: IDLE, START, DATA, PARITY, STOP.
REQ-015 IDLE: divider held cleared and disabled; a synchronized 1->0 transition SHALL move to START the next cycle.
REQ-016 START: divider enabled; at first mid-bit mark, sampled 0 -> DATA; sampled 1 -> IDLE (glitch rejected, no output pulse).
REQ-017 DATA: one bit shifted in per mark, 3-bit counter 0..7; after bit 7 -> PARITY if PARITY_TYPE != "none", else STOP.
REQ-018 PARITY: sample at mark; error when XOR(data, parity bit) is 1 for "even" or 0 for "odd"; -> STOP.
REQ-019 STOP: at mark, sampled 1 -> DOUT updated, DOUT_VLD=1 (PARITY_ERROR=1 too on mismatch) on the following cycle; sampled 0 -> FRAME_ERROR=1, DOUT and DOUT_VLD unchanged; both -> IDLE.
REQ-020 Return to IDLE occurs at mid stop bit, so a start edge directly after the stop bit SHALL be accepted (back-to-back frames, no gap).
REQ-021 After a frame error with line held low (break), no new frame SHALL start until the line returns high and falls again.
REQ-022 DOUT SHALL hold its value between valid frames; DOUT_VLD, FRAME_ERROR, PARITY_ERROR SHALL never exceed one cycle.
REQ-023 FRAME_ERROR and DOUT_VLD SHALL never be asserted in the same cycle.

Reset
REQ-024 RST asserted SHALL immediately force FSM=IDLE, DOUT=0x00, DOUT_VLD=0, FRAME_ERROR=0, PARITY_ERROR=0, bit counter=0, shift register=0.
REQ-025 RST mid-frame SHALL abort the frame with no output pulse; reception resumes at the next start edge after release.

Structure
REQ-026 Shared package uart_pkg SHALL hold the FSM state encoding and parity-type constants, reused by the future uart_tx.
REQ-027 Bit timing SHALL come from one instance of the existing uart_clk_div block (CLEAR driven in IDLE, ENABLE outside IDLE, DIV_MARK used as sample strobe).
REQ-028 Synchronizer, FSM, shift register and parity check reside in uart_rx; no further sub-modules.

Verification (CLK_FREQ=1600000, BAUD_RATE=100000 -> 16 clk/bit)
REQ-029 Frame 0xA5, parity "none" -> DOUT=0xA5, single DOUT_VLD pulse, about 152 clk after the start edge.
REQ-030 Frames 0x00, 0xFF, 0x3C back-to-back, zero idle gap -> three DOUT_VLD pulses with 0x00, 0xFF, 0x3C in order.
REQ-031 Frame 0x55 with stop bit 0, then line held low 40 bits -> one FRAME_ERROR, no DOUT_VLD, no further activity until line high and a new frame.
REQ-032 Low glitch of 4 clk on idle line -> no output pulse; FSM back in IDLE.
REQ-033 PARITY_TYPE="even", frame 0x07 with parity bit 0 -> DOUT=0x07 with DOUT_VLD and PARITY_ERROR in the same cycle.
REQ-034 RST pulsed during data bit 4 of a frame -> no pulse for that frame; next frame 0x81 received correctly.
